alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
Initiator side of the registered N-bit ALU interface. Accepts operand/operation commands over a valid/ready handshake, drives the ALU's opnd1/opnd2/operation inputs, and waits out the ALU's one-cycle registered latency. It then captures the ALU result register and returns it over a valid/ready response channel. Supports result chaining, where the previous result replaces opnd1, and counts completed responses.

Parameters:
N, 4, operand/result width; must match the ALU instance.
CNT_W, 8, width of the completed-response counter.

Ports:
clk  input  1  system clock; all state updates on its rising edge
reset  input  1  asynchronous, active-high reset; shared with the ALU instance
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_opnd1  input  N  operand 1; ignored when cmd_chain=1
cmd_opnd2  input  N  operand 2
cmd_op  input  2  ALU operation: 00 add, 01 sub, 10 and, 11 or
cmd_chain  input  1  1 = use the last completed result as operand 1
opnd1  output  N  to ALU operand 1 (registered)
opnd2  output  N  to ALU operand 2 (registered)
operation  output  2  to ALU operation select (registered)
alu_result  input  N  from ALU registered result output
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_result  output  N  captured ALU result
rsp_count  output  CNT_W  number of responses accepted by the consumer
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, any state): state=IDLE. opnd1, opnd2, operation, rsp_result, rsp_count and last_result are 0. rsp_valid=0, busy=0, cmd_ready=1.
- FSM states: IDLE, ISSUE, CAPTURE, RESP. cmd_ready = (state==IDLE), as a combinational decode of the state register.
- IDLE: on a clk edge with cmd_valid&&cmd_ready:
  - opnd1 <= cmd_chain ? last_result : cmd_opnd1
  - opnd2 <= cmd_opnd2; operation <= cmd_op
  - next state ISSUE
  - With no accept, all outputs hold.
- ISSUE: the ALU computes combinationally from the registered operands, and its result register loads at this edge. Next state CAPTURE unconditionally.
- CAPTURE: rsp_result <= alu_result; last_result <= alu_result; rsp_valid <= 1; next state RESP.
- RESP:
  - rsp_valid held at 1 and rsp_result held stable while rsp_ready=0; the state waits indefinitely.
  - On rsp_valid&&rsp_ready: rsp_valid <= 0, rsp_count <= rsp_count+1, next state IDLE.
- Latency: command accepted at edge E0; rsp_valid high after E2 (two cycles). Maximum throughput is one command per 4 cycles with rsp_ready tied high.
- opnd1/opnd2/operation hold their last issued values in all states; they are never cleared except by reset.
- cmd_valid while not in IDLE is ignored, with no buffering. The command source must hold cmd_valid and cmd fields stable until accepted.
- Chain with no prior completed command uses last_result=0.
- last_result updates in CAPTURE regardless of later backpressure.
- rsp_count wraps from 2^CNT_W-1 to 0 without any flag.
- Arithmetic is performed by the ALU modulo 2^N. The sequencer passes values through unmodified and never sign-extends.
- Reset asserted mid-command (ISSUE/CAPTURE/RESP): the in-flight command is discarded and no response is produced. After reset deassertion the block is in IDLE with cmd_ready=1.
- X on cmd_* while cmd_valid=0 must not propagate to any register.

Test Plan:
- Basic add, N=4: cmd_op=00, opnd1=7, opnd2=5, rsp_ready=1 -> rsp_valid high 2 cycles after accept, rsp_result=0xC, rsp_count=1, cmd_ready back to 1 one cycle after the response handshake.
- Subtract wrap: cmd_op=01, opnd1=3, opnd2=5 -> rsp_result=0xE; and/or: 0xA&0x6 -> 0x2, 0xA|0x5 -> 0xF.
- Chaining: add 9+8 -> rsp_result=0x1, then cmd_chain=1, cmd_op=10, cmd_opnd1=0xF (ignored), opnd2=3 -> opnd1 driven =1, rsp_result=0x1. Chain directly after reset with op=11, opnd2=4 -> rsp_result=0x4.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid and rsp_result stable, cmd_ready=0, busy=1, and cmd_valid pulses during the stall are ignored. rsp_ready=1 -> one handshake, count +1.
- Reset mid-operation: assert reset in ISSUE (and separately in RESP) -> rsp_valid=0 and all outputs 0 immediately (async). No response after release; next command completes normally with rsp_count=1.
- Counter wrap with CNT_W=2: 5 back-to-back commands -> rsp_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Initiator for a registered N-bit ALU: takes commands over valid/ready, drives the ALU,
// waits out its one-cycle latency, and returns the captured result over valid/ready.
module alu_cmd_sequencer #(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [N-1:0]     cmd_opnd1,
  input  logic [N-1:0]     cmd_opnd2,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_chain,
  output logic [N-1:0]     opnd1,
  output logic [N-1:0]     opnd2,
  output logic [1:0]       operation,
  input  logic [N-1:0]     alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [N-1:0]     rsp_result,
  output logic [CNT_W-1:0] rsp_count,
  output logic             busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  logic [1:0]   state_r;
  logic [1:0]   state_s;
  logic [N-1:0] last_result_r;
  logic         accept_s;
  logic         rsp_done_s;

  assign cmd_ready  = (state_r == IDLE);
  assign busy       = (state_r != IDLE);
  // Command fields are only sampled on an accept, so X on idle inputs never reaches state.
  assign accept_s   = cmd_valid && cmd_ready;
  assign rsp_done_s = (state_r == RESP) && rsp_valid && rsp_ready;

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE:   state_s = CAPTURE;
      CAPTURE: state_s = RESP;
      RESP: begin
        if (rsp_done_s) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // ALU operand and operation registers; they keep the last issued command until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opnd1     <= {N{1'b0}};
      opnd2     <= {N{1'b0}};
      operation <= 2'b00;
    end else if (accept_s) begin
      opnd1     <= cmd_chain ? last_result_r : cmd_opnd1;
      opnd2     <= cmd_opnd2;
      operation <= cmd_op;
    end
  end

  // Result capture, response handshake and completed-response counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_result    <= {N{1'b0}};
      last_result_r <= {N{1'b0}};
      rsp_valid     <= 1'b0;
      rsp_count     <= {CNT_W{1'b0}};
    end else if (state_r == CAPTURE) begin
      rsp_result    <= alu_result;
      last_result_r <= alu_result;
      rsp_valid     <= 1'b1;
    end else if (rsp_done_s) begin
      rsp_valid     <= 1'b0;
      rsp_count     <= rsp_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: directed cases from the plan plus random
// commands, checked against a command-level reference model.
module tb_alu_cmd_sequencer;

  localparam int N     = 4;
  localparam int CNT_W = 2;
  localparam int MOD   = 16;
  localparam int CMOD  = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [N-1:0]     cmd_opnd1;
  logic [N-1:0]     cmd_opnd2;
  logic [1:0]       cmd_op;
  logic             cmd_chain;
  logic [N-1:0]     opnd1;
  logic [N-1:0]     opnd2;
  logic [1:0]       operation;
  logic [N-1:0]     alu_result;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [N-1:0]     rsp_result;
  logic [CNT_W-1:0] rsp_count;
  logic             busy;

  int n_checks = 0;
  int n_pass   = 0;
  int model_last = 0;
  int model_cnt  = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.N(N), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opnd1  (cmd_opnd1),
    .cmd_opnd2  (cmd_opnd2),
    .cmd_op     (cmd_op),
    .cmd_chain  (cmd_chain),
    .opnd1      (opnd1),
    .opnd2      (opnd2),
    .operation  (operation),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_count  (rsp_count),
    .busy       (busy)
  );

  // Registered ALU that the sequencer drives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_result <= 4'h0;
    end else begin
      case (operation)
        2'b00:   alu_result <= opnd1 + opnd2;
        2'b01:   alu_result <= opnd1 - opnd2;
        2'b10:   alu_result <= opnd1 & opnd2;
        default: alu_result <= opnd1 | opnd2;
      endcase
    end
  end

  function automatic int ref_alu(input int a, input int b, input int op);
    case (op)
      0:       return (a + b) % MOD;
      1:       return (a - b + MOD) % MOD;
      2:       return a & b;
      default: return a | b;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_opnd1"},     32'(opnd1),      32'd0);
    check_eq({tag, "_opnd2"},     32'(opnd2),      32'd0);
    check_eq({tag, "_operation"}, 32'(operation),  32'd0);
    check_eq({tag, "_rsp_valid"}, 32'(rsp_valid),  32'd0);
    check_eq({tag, "_rsp_res"},   32'(rsp_result), 32'd0);
    check_eq({tag, "_rsp_count"}, 32'(rsp_count),  32'd0);
    check_eq({tag, "_busy"},      32'(busy),       32'd0);
    check_eq({tag, "_cmd_ready"}, 32'(cmd_ready),  32'd1);
  endtask

  task automatic drive_cmd(input int a, input int b, input int op, input bit chain);
    cmd_valid = 1'b1;
    cmd_opnd1 = 4'(a);
    cmd_opnd2 = 4'(b);
    cmd_op    = 2'(op);
    cmd_chain = chain;
  endtask

  task automatic idle_cmd();
    cmd_valid = 1'b0;
    cmd_opnd1 = 4'bxxxx;
    cmd_opnd2 = 4'bxxxx;
    cmd_op    = 2'bxx;
    cmd_chain = 1'bx;
  endtask

  // One full command: accept, latency, optional stall with ignored commands, handshake.
  task automatic do_cmd(input int a, input int b, input int op, input bit chain, input int stall);
    int a_eff;
    int exp;
    logic [N-1:0] held;
    a_eff = chain ? model_last : a;
    exp   = ref_alu(a_eff, b, op);
    @(negedge clk);
    check_eq("idle_ready", 32'(cmd_ready), 32'd1);
    drive_cmd(a, b, op, chain);
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    idle_cmd();
    check_eq("opnd1", 32'(opnd1), 32'(a_eff));
    check_eq("opnd2", 32'(opnd2), 32'(b));
    check_eq("operation", 32'(operation), 32'(op));
    check_eq("issue_ready", 32'(cmd_ready), 32'd0);
    check_eq("issue_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check_eq("capture_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    check_eq("rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("rsp_result", 32'(rsp_result), 32'(exp));
    model_last = exp;
    held = rsp_result;
    for (int i = 0; i < stall; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        drive_cmd(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end else begin
        idle_cmd();
      end
      @(posedge clk); #1;
      check_eq("stall_valid", 32'(rsp_valid), 32'd1);
      check_eq("stall_result", 32'(rsp_result), 32'(held));
      check_eq("stall_ready", 32'(cmd_ready), 32'd0);
      check_eq("stall_busy", 32'(busy), 32'd1);
      check_eq("stall_opnd2", 32'(opnd2), 32'(b));
    end
    idle_cmd();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    model_cnt = (model_cnt + 1) % CMOD;
    check_eq("done_valid", 32'(rsp_valid), 32'd0);
    check_eq("rsp_count", 32'(rsp_count), 32'(model_cnt));
    check_eq("done_ready", 32'(cmd_ready), 32'd1);
  endtask

  // Accept a command, advance `edges` more clocks, then assert reset mid-cycle.
  task automatic reset_during(input int edges, input string tag);
    @(negedge clk);
    drive_cmd(6, 7, 0, 1'b0);
    @(posedge clk); #1;
    idle_cmd();
    for (int i = 0; i < edges; i++) begin
      @(posedge clk); #1;
    end
    #2;
    reset = 1'b1;
    #1;
    model_last = 0;
    model_cnt  = 0;
    check_reset_outputs(tag);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_eq({tag, "_no_rsp"}, 32'(rsp_valid), 32'd0);
    end
  endtask

  initial begin
    reset     = 1'b1;
    rsp_ready = 1'b0;
    idle_cmd();
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("post_reset");

    do_cmd(4'hF, 4, 3, 1'b1, 0);   // chain straight after reset: 0|4
    do_cmd(7, 5, 0, 1'b0, 0);
    do_cmd(3, 5, 1, 1'b0, 0);
    do_cmd(4'hA, 6, 2, 1'b0, 0);
    do_cmd(4'hA, 5, 3, 1'b0, 0);
    do_cmd(9, 8, 0, 1'b0, 0);
    do_cmd(4'hF, 3, 2, 1'b1, 0);   // chained: opnd1 = 1
    do_cmd(2, 3, 0, 1'b0, 5);      // backpressure

    reset_during(0, "rst_issue");
    do_cmd(1, 2, 0, 1'b0, 0);
    reset_during(2, "rst_resp");
    do_cmd(5, 6, 1, 1'b0, 1);

    for (int k = 0; k < 40; k++) begin
      do_cmd(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
             int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
